// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes operand1 - operand2 as A + ~B + 1, one bit per clock, LSB first.
// The result and the C/Z/N/V flags are loaded together on the edge that processes the last bit.
module serial_subtractor #(
  parameter int WIDTH       = 8,
  parameter int ST_CARRY    = 0,
  parameter int ST_ZERO     = 1,
  parameter int ST_NEG      = 2,
  parameter int ST_OVERFLOW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             b_inv;
  logic             sum;
  logic             cout;
  logic [WIDTH-1:0] full;
  logic [3:0]       flags;

  // On the final bit, a_reg[0]/b_reg[0] hold the operand sign bits, so the
  // overflow test needs no separately stored copy of the operands.
  always_comb begin
    b_inv = ~b_reg[0];
    sum   = a_reg[0] ^ b_inv ^ carry;
    cout  = (a_reg[0] & b_inv) | (a_reg[0] & carry) | (b_inv & carry);
    full  = {sum, acc[WIDTH-1:1]};
    flags = '0;
    flags[ST_CARRY]    = cout;
    flags[ST_ZERO]     = (full == '0);
    flags[ST_NEG]      = sum;
    flags[ST_OVERFLOW] = (a_reg[0] != b_reg[0]) && (sum != a_reg[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      statusOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= operand1;
            b_reg <= operand2;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b1;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= full;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result    <= full;
            statusOut <= flags;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       status;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [3:0]       s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .operand1 (operand1),
    .operand2 (operand2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .statusOut(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_single_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", int'(result), int'(e.r));
        check("status_vnzc", int'(status), int'(e.s));
      end
    end
    prev_done = done;
  end

  // Flags written {V,N,Z,C}.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] er, input logic [3:0] es,
                        input bit disturb);
    int   n;
    int   bc;
    exp_t e;
    @(negedge clk);
    start = 1'b1; operand1 = a; operand2 = b;
    e.r = er; e.s = es;
    sb.push_back(e);
    @(posedge clk); #1;
    check("busy_after_accept", int'(busy), 1);
    n = 0; bc = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (disturb && n == 2) begin start = 1'b1; operand1 = 8'hFF; operand2 = 8'h00; end
      if (disturb && n == 3) begin start = 1'b0; operand1 = 8'h55; operand2 = 8'hAA; end
      if (busy) bc++;
      if (done) break;
    end
    check("done_latency", n - 1, WIDTH);
    check("busy_cycles", bc, WIDTH);
  endtask

  task automatic count_done(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) k++;
    end
  endtask

  initial begin
    int k;
    int last;
    int n;
    rst = 1'b1; start = 1'b0; operand1 = '0; operand2 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_status", int'(status), 0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 8'h02, 4'b0001, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 4'b0100, 1'b0);
    run_op(8'h2A, 8'h2A, 8'h00, 4'b0011, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 4'b1001, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 4'b1100, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 4'b0100, 1'b0);
    run_op(8'hFF, 8'h00, 8'hFF, 4'b0101, 1'b0);

    // start pulse and operand changes during SHIFT must be ignored
    run_op(8'h10, 8'h01, 8'h0F, 4'b0001, 1'b1);
    count_done(12, k);
    check("no_extra_done", k, 0);

    // reset in the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    start = 1'b1; operand1 = 8'h33; operand2 = 8'h11;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_status", int'(status), 0);
    @(negedge clk);
    rst = 1'b0;
    count_done(14, k);
    check("abort_no_done", k, 0);
    run_op(8'h09, 8'h04, 8'h05, 4'b0001, 1'b0);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; operand1 = 8'h40; operand2 = 8'h41;
    repeat (3) sb.push_back(exp_t'{r: 8'hFF, s: 4'b0100});
    k = 0; last = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        k++;
        if (k > 1) check("b2b_period", cyc - last, WIDTH + 2);
        last = cyc;
        if (k == 3) begin start = 1'b0; break; end
      end
    end
    check("b2b_count", k, 3);
    count_done(14, k);
    check("b2b_no_fourth", k, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
